// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg
// Pointer encoding helpers shared by the write-side and read-side FIFO
// controllers.
//
// Both functions work on a zero-extended PTR_MAX_W-bit container so one
// definition serves every pointer width. Callers cast their narrow pointer
// in and cast the result back to their width. Zero extension does not
// change the result in either direction:
// - the extra upper bits of a Gray code are 0;
// - the prefix XOR runs through those zero bits without altering the lower
//   bits.
package fifo_ptr_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB: each binary bit is the XOR of all Gray bits
  // at and above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
// Multi-flop synchroniser for a Gray-coded FIFO pointer that crosses
// into this clock domain. Only one bit of the pointer changes per step.
// A bit caught mid-transition therefore resolves to either the old pointer
// or the new one, and never to an unrelated value.
//
// Ports
//   clock  destination-domain clock
//   reset  asynchronous, active-high; clears every stage
//   d      Gray pointer from the other domain (asynchronous)
//   q      synchronised Gray pointer, STAGES edges behind d
module gray_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl
// Write-side controller of the clock-crossing FIFO between the BT.656
// capture domain and the Avalon-ST output domain. It does the following:
// - takes words from a valid/ready stream and drives the RAM write port;
// - keeps the write pointer in binary and publishes it in Gray;
// - synchronises the read side's Gray pointer back into this domain;
// - derives full, almost-full and the fill level from the two pointers.
//
// Ports
//   clock, reset       write-domain clock, asynchronous active-high reset
//   in_data/valid      upstream word and its valid flag
//   in_ready           word can be accepted (low only when full)
//   mem_we/waddr/wdata registered RAM write port
//   wr_ptr_gray        registered Gray write pointer, to the read domain
//   rd_ptr_gray_async  Gray read pointer from the read domain
//   full, almost_full  level == DEPTH, level >= AFULL_LEVEL
//   wr_level           words stored, as seen from this side
module async_fifo_wr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 3,
  parameter int AFULL_LEVEL = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] rd_gray_s;
  logic [PTR_W-1:0] rd_bin_s;
  logic             accept;

  gray_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clock (clock),
    .reset (reset),
    .d     (rd_ptr_gray_async),
    .q     (rd_gray_s)
  );

  assign rd_bin_s = PTR_W'(gray2bin(ptr_t'(rd_gray_s)));

  // The extra pointer bit separates full (difference DEPTH) from empty
  // (difference 0). A read advance shows up here only after the
  // synchroniser, so the level can only overestimate. That is the safe
  // direction.
  assign wr_level    = wr_bin - rd_bin_s;
  assign full        = (wr_level == PTR_W'(DEPTH));
  assign almost_full = (wr_level >= PTR_W'(AFULL_LEVEL));
  assign in_ready    = !full;
  assign accept      = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_bin    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_waddr <= wr_bin[ADDR_WIDTH-1:0];
        mem_wdata <= in_data;
        wr_bin    <= wr_bin + 1'b1;
      end
    end
  end

  // The Gray pointer is taken from wr_bin after it has advanced. It is
  // therefore published one edge after the RAM write is issued, so the
  // word is in RAM before the read side can see the pointer move.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_gray <= '0;
    end else begin
      wr_ptr_gray <= PTR_W'(bin2gray(ptr_t'(wr_bin)));
    end
  end

endmodule
